// File: rtl/nios2_mycpu_oci_pkg.sv
// Shared OCI trace definitions: atom codes, DCT buffer geometry and packer FSM states.
package nios2_mycpu_oci_pkg;
    localparam int DCT_BUF_W = 30;
    localparam int DCT_CNT_W = 4;

    localparam logic [1:0] ATOM_NT  = 2'b00;
    localparam logic [1:0] ATOM_TK  = 2'b01;
    localparam logic [1:0] ATOM_IND = 2'b10;
    localparam logic [1:0] ATOM_EXC = 2'b11;

    typedef enum logic [1:0] {RUN, ENDING, ENDED} dct_state_e;
endpackage

// File: rtl/nios2_mycpu_oci_dct_outreg.sv
// Completed-frame output register with valid/ready handshake; accepts a new
// frame in the same cycle the held one is taken, so streams run without bubbles.
module nios2_mycpu_oci_dct_outreg
    import nios2_mycpu_oci_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DCT_BUF_W-1:0] ld_data,
    input  logic [DCT_CNT_W-1:0] ld_count,
    input  logic                 frm_ready,
    output logic                 frm_valid,
    output logic [DCT_BUF_W-1:0] frm_data,
    output logic [DCT_CNT_W-1:0] frm_count,
    output logic                 can_load
);
    assign can_load = !frm_valid || frm_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frm_valid <= 1'b0;
            frm_data  <= '0;
            frm_count <= '0;
        end else if (load) begin
            frm_valid <= 1'b1;
            frm_data  <= ld_data;
            frm_count <= ld_count;
        end else if (frm_ready) begin
            frm_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/nios2_mycpu_oci_dct_packer.sv
// Packs 2-bit DCT trace atoms into frames of up to MAX_ATOMS, with flush,
// idle timeout and end-of-test drain sequencing.
module nios2_mycpu_oci_dct_packer
    import nios2_mycpu_oci_pkg::*;
#(
    parameter int MAX_ATOMS  = 15,
    parameter int IDLE_FLUSH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 atom_valid,
    input  logic [1:0]           atom,
    output logic                 atom_ready,
    input  logic                 flush,
    input  logic                 test_ending,
    output logic                 frm_valid,
    input  logic                 frm_ready,
    output logic [DCT_BUF_W-1:0] frm_data,
    output logic [DCT_CNT_W-1:0] frm_count,
    output logic [DCT_BUF_W-1:0] dct_buffer,
    output logic [DCT_CNT_W-1:0] dct_count,
    output logic                 test_has_ended
);
    localparam int IDLE_W = (IDLE_FLUSH > 0) ? $clog2(IDLE_FLUSH + 1) : 1;
    localparam logic [IDLE_W-1:0]    IDLE_MAX = IDLE_W'(IDLE_FLUSH);
    localparam logic [DCT_CNT_W-1:0] LAST_IDX = DCT_CNT_W'(MAX_ATOMS - 1);
    localparam logic [DCT_CNT_W-1:0] MAX_CNT  = DCT_CNT_W'(MAX_ATOMS);

    dct_state_e           state;
    logic                 flush_pend;
    logic [IDLE_W-1:0]    idle_cnt;
    logic                 can_load;
    logic                 flush_req, timeout, accept, emit_req, emit;
    logic [DCT_BUF_W-1:0] buf_nxt;
    logic [DCT_CNT_W-1:0] cnt_nxt;

    always_comb begin
        flush_req  = flush || flush_pend;
        timeout    = (IDLE_FLUSH != 0) && (idle_cnt == IDLE_MAX) && (dct_count != '0);
        // Stall the producer only when this cycle must emit and the output is still occupied.
        atom_ready = !reset && (state == RUN) &&
                     (can_load || !((dct_count == LAST_IDX) || flush_req || timeout));
        accept     = atom_valid && atom_ready;
        buf_nxt    = dct_buffer;
        if (accept)
            buf_nxt[{dct_count, 1'b0} +: 2] = atom;
        cnt_nxt    = dct_count + DCT_CNT_W'(accept);
        emit_req   = 1'b0;
        case (state)
            RUN:     emit_req = (accept && cnt_nxt == MAX_CNT) ||
                                (flush_req && cnt_nxt != '0) || timeout;
            ENDING:  emit_req = (dct_count != '0);
            default: emit_req = 1'b0;
        endcase
        emit = emit_req && can_load;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= RUN;
            dct_buffer     <= '0;
            dct_count      <= '0;
            flush_pend     <= 1'b0;
            idle_cnt       <= '0;
            test_has_ended <= 1'b0;
        end else begin
            if (emit) begin
                dct_buffer <= '0;
                dct_count  <= '0;
            end else begin
                dct_buffer <= buf_nxt;
                dct_count  <= cnt_nxt;
            end
            flush_pend <= (state == RUN) && !emit && flush_req && (cnt_nxt != '0);
            if ((state != RUN) || accept || emit)
                idle_cnt <= '0;
            else if ((dct_count != '0) && (idle_cnt != IDLE_MAX))
                idle_cnt <= idle_cnt + 1'b1;
            case (state)
                RUN: if (test_ending) state <= ENDING;
                ENDING: if ((dct_count == '0) && can_load) begin
                    state          <= ENDED;
                    test_has_ended <= 1'b1;
                end
                default: test_has_ended <= 1'b1;
            endcase
        end
    end

    nios2_mycpu_oci_dct_outreg u_outreg (
        .clk       (clk),
        .reset     (reset),
        .load      (emit),
        .ld_data   (buf_nxt),
        .ld_count  (cnt_nxt),
        .frm_ready (frm_ready),
        .frm_valid (frm_valid),
        .frm_data  (frm_data),
        .frm_count (frm_count),
        .can_load  (can_load)
    );
endmodule

// File: doc/nios2_mycpu_oci_dct_packer.md
Name: nios2_mycpu_oci_dct_packer

Overview:
- Packs 2-bit direct-control-transfer (DCT) trace atoms from the CPU trace interface into 30-bit frames of up to 15 atoms.
- Sits directly upstream of the OCI test bench and the trace frame FIFO.
- Drives the live dct_buffer/dct_count view to the test bench and emits completed frames over a valid/ready handshake.
- Sequences the end-of-test flush and raises test_has_ended.

Parameters:
- MAX_ATOMS, 15: atoms per full frame (1..15).
- IDLE_FLUSH, 64: idle cycles with a partial frame before a forced flush; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- atom_valid  in  1  atom offered
- atom  in  2  atom code: 00 not-taken, 01 taken, 10 indirect, 11 exception
- atom_ready  out  1  atom accepted this cycle when atom_valid=1
- flush  in  1  single-cycle request to emit the partial frame
- test_ending  in  1  level; CPU test is finishing
- frm_valid  out  1  frame held in the output register
- frm_ready  in  1  downstream accepts the frame
- frm_data  out  30  packed atoms; atom k at bits [2k+1:2k]
- frm_count  out  4  atoms in the frame (1..MAX_ATOMS)
- dct_buffer  out  30  live accumulator contents
- dct_count  out  4  live accumulator atom count
- test_has_ended  out  1  sticky; final frame delivered

Behaviour:
- Reset (asynchronous, any time, including mid-frame): all outputs 0, accumulator and output register cleared, idle counter 0, FSM in RUN. Atoms in flight are discarded.
- Accumulator:
  - An accepted atom is written at bits [2*dct_count+1 : 2*dct_count].
  - dct_count increments one cycle after acceptance (registered, latency 1).
  - Unused high bits read 0.
- Frame emission is triggered by any of:
  - (a) an accepted atom makes the count reach MAX_ATOMS;
  - (b) flush=1 with dct_count>0;
  - (c) the idle counter reaches IDLE_FLUSH with dct_count>0;
  - (d) the ENDING drain.
- On emission:
  - The accumulator, including any atom accepted that same cycle, moves to frm_data/frm_count.
  - frm_valid rises on the next edge.
  - The accumulator clears in the same edge.
  - A flush with dct_count=0 and no atom that cycle is ignored.
- Output register:
  - Emission is allowed when frm_valid=0, or when frm_valid=1 and frm_ready=1 (back-to-back, no bubble).
  - frm_data and frm_count hold stable while frm_valid=1 and frm_ready=0.
- Backpressure: atom_ready=0 when an emission is required this cycle but the output register cannot take it. The cases are dct_count==MAX_ATOMS-1, a pending flush or timeout, or ENDING. Otherwise atom_ready=1 in RUN.
- Pending flush: a flush that cannot emit is latched and retried each cycle until it emits; it does not re-arm.
- Idle counter:
  - Increments while dct_count>0 and no atom is accepted.
  - Clears on acceptance or on emission.
  - Saturates at IDLE_FLUSH.
- FSM:
  - RUN -> ENDING on test_ending=1.
  - ENDING: atom_ready=0. The partial frame is emitted as soon as the output register allows.
  - ENDING -> ENDED when the accumulator is empty and (frm_valid=0, or frm_valid=1 with frm_ready=1).
  - ENDED: test_has_ended=1 (sticky). atom_ready=0, flush ignored. Leaves ENDED only on reset.
  - test_ending dropping after ENDING is entered is ignored.
- Simultaneous events:
  - Atom and flush in the same cycle: the atom is included in the flushed frame.
  - Atom completing a frame plus flush: one frame only.
  - test_ending plus an atom in the same RUN cycle: the atom is accepted, then ENDING is entered.
- Width rules: frm_count never 0 while frm_valid=1, and never exceeds MAX_ATOMS.

Decomposition:
- Shared package nios2_mycpu_oci_pkg holds:
  - the atom code constants (ATOM_NT, ATOM_TK, ATOM_IND, ATOM_EXC);
  - DCT_BUF_W=30 and DCT_CNT_W=4;
  - the FSM state enum {RUN, ENDING, ENDED}.
- One natural sub-module, nios2_mycpu_oci_dct_outreg: the frame output register plus valid/ready skid logic.
- The accumulator, idle counter and FSM stay in the top.

Test Plan:
- 15 atoms 01 on consecutive cycles with frm_ready=1 -> one frame, frm_data=0x15555555, frm_count=15; dct_count returns to 0; atom_ready stays 1 throughout.
- Atoms 00,01,10 then flush -> frm_data=0x24, frm_count=3, frm_valid one cycle after the flush.
- frm_ready=0 with 30 atoms offered -> first frame held stable; atom_ready=0 while dct_count=14; the 30th atom is not accepted until frm_ready=1, and then emits without a bubble.
- 5 atoms, then idle, IDLE_FLUSH=64 -> frame frm_count=5 emitted after the 64th idle cycle; an idle accumulator never emits.
- 7 atoms, test_ending=1, frm_ready=1 -> frame frm_count=7, then test_has_ended=1; later atoms and flush are ignored until reset.
- Reset asserted mid-frame (dct_count=9) with frm_valid=1 -> all outputs 0 immediately (asynchronous), no frame emitted after release.
